phase_monitor_accum: RTL and testbench



---
 rtl/phase_monitor_accum.sv | 169 ++++++++++++++++
 tb/tb_phase_monitor_accum.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/phase_monitor_accum.sv
// Phase monitor accumulator: synchronizes the sampling sub-cell's two flops,
// holds them out of clear while a measurement runs, and over a window of
// clock cycles counts samples where the flops disagree and where ff_in leads.
// Control outputs are registered from the current state, so each of them
// follows the FSM by one cycle.
module phase_monitor_accum #(
  parameter int WIN_W   = 16,
  parameter int ARM_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_pm,
  input  logic [WIN_W-1:0] n_avg,
  input  logic             ff_in,
  input  logic             ff_ref,
  output logic             en_sync,
  output logic             busy,
  output logic             done,
  output logic [WIN_W-1:0] cnt_diff,
  output logic [WIN_W-1:0] cnt_lead
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam logic [WIN_W-1:0] ARM_LAST = WIN_W'(ARM_CYC - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_start;
  logic             w_abort;
  logic             w_phaseEnd;
  logic             w_sample;

  logic             r_inMeta;
  logic             r_inSync;
  logic             r_refMeta;
  logic             r_refSync;

  logic [WIN_W-1:0] r_win;
  logic [WIN_W-1:0] r_cyc;
  logic [WIN_W-1:0] r_cntDiff;
  logic [WIN_W-1:0] r_cntLead;
  logic             r_enSync;
  logic             r_busy;
  logic             r_done;

  // Next-state decode: start on en_pm in IDLE, leave ARM/ACCUM when their
  // cycle counter expires, and fall back to IDLE whenever en_pm drops mid-run.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_abort    = 1'b0;
    w_phaseEnd = 1'b0;
    w_sample   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en_pm) begin
          w_next  = S_ARM;
          w_start = 1'b1;
        end
      end
      S_ARM: begin
        if (!en_pm) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cyc == ARM_LAST) begin
          w_phaseEnd = 1'b1;
          w_next     = (r_win == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (!en_pm) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_sample = 1'b1;
          if (r_cyc == (r_win - WIN_W'(1))) begin
            w_phaseEnd = 1'b1;
            w_next     = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!en_pm) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Two-flop synchronizers bringing the asynchronous sample flops into clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inMeta  <= 1'b0;
      r_inSync  <= 1'b0;
      r_refMeta <= 1'b0;
      r_refSync <= 1'b0;
    end else begin
      r_inMeta  <= ff_in;
      r_inSync  <= r_inMeta;
      r_refMeta <= ff_ref;
      r_refSync <= r_refMeta;
    end
  end

  // Window latch, phase cycle counter and the two result counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win     <= '0;
      r_cyc     <= '0;
      r_cntDiff <= '0;
      r_cntLead <= '0;
    end else if (w_start) begin
      r_win     <= n_avg;
      r_cyc     <= '0;
      r_cntDiff <= '0;
      r_cntLead <= '0;
    end else if (w_abort) begin
      r_cyc     <= '0;
      r_cntDiff <= '0;
      r_cntLead <= '0;
    end else begin
      if (w_sample) begin
        r_cntDiff <= r_cntDiff + WIN_W'(r_inSync ^ r_refSync);
        r_cntLead <= r_cntLead + WIN_W'(r_inSync & ~r_refSync);
      end
      if ((r_state == S_ARM) || (r_state == S_ACCUM)) begin
        r_cyc <= w_phaseEnd ? '0 : (r_cyc + WIN_W'(1));
      end
    end
  end

  // Registered status outputs decoded from the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enSync <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_enSync <= (r_state == S_ARM) || (r_state == S_ACCUM);
      r_busy   <= (r_state == S_ARM) || (r_state == S_ACCUM);
      r_done   <= (r_state == S_DONE);
    end
  end

  assign en_sync  = r_enSync;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cnt_diff = r_cntDiff;
  assign cnt_lead = r_cntLead;

endmodule

// File: tb/tb_phase_monitor_accum.sv
// Self-checking bench for phase_monitor_accum. A behavioural model counts the
// logged sample-flop values that fall inside each measurement window, allowing
// for the two-cycle synchronizer delay, and predicts the control outputs from
// the window timing (start, ARM_CYC settle cycles, win samples, then done).
module tb_phase_monitor_accum;

  localparam int WIN_W    = 16;
  localparam int ARM_CYC  = 4;
  localparam int SYNC_LAT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en_pm;
  logic [WIN_W-1:0] n_avg;
  logic             ff_in;
  logic             ff_ref;
  logic             en_sync;
  logic             busy;
  logic             done;
  logic [WIN_W-1:0] cnt_diff;
  logic [WIN_W-1:0] cnt_lead;

  int checkCount = 0;
  int failCount  = 0;

  logic inLog  [0:511];
  logic refLog [0:511];

  phase_monitor_accum #(.WIN_W(WIN_W), .ARM_CYC(ARM_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_pm    (en_pm),
    .n_avg    (n_avg),
    .ff_in    (ff_in),
    .ff_ref   (ff_ref),
    .en_sync  (en_sync),
    .busy     (busy),
    .done     (done),
    .cnt_diff (cnt_diff),
    .cnt_lead (cnt_lead)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive the sample flops for cycle k and remember what was driven.
  // mode 0: static lead, 1: ff_in toggling with ff_ref low,
  // 2: identical random stream, 3: independent random streams.
  task automatic applyStimulus(input int mode, input int k);
    logic a;
    logic b;
    case (mode)
      0: begin a = 1'b1;       b = 1'b0; end
      1: begin a = k[0];       b = 1'b0; end
      2: begin a = 1'($urandom); b = a;  end
      default: begin a = 1'($urandom); b = 1'($urandom); end
    endcase
    ff_in     = a;
    ff_ref    = b;
    inLog[k]  = a;
    refLog[k] = b;
  endtask

  int expDiff;
  int expLead;

  // One measurement: start at k=0, optional abort at abortK, optional hold of
  // en_pm until holdK, optional n_avg change at newNAt. k counts clock edges
  // after the start edge; outputs are sampled 1ns after each edge.
  task automatic runMeasure(input int win, input int mode, input int abortK,
                            input int holdK, input int newNAt, input int newN);
    int  endK;
    bit  aborted;
    bit  expActive;
    bit  expDone;
    logic si;
    logic sr;
    expDiff = 0;
    expLead = 0;
    if (abortK >= 0) endK = abortK + 2;
    else if (holdK > 1 + ARM_CYC + win) endK = holdK;
    else endK = 1 + ARM_CYC + win + 2;
    for (int k = 0; k <= endK; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rst   = 1'b0;
        en_pm = 1'b1;
        n_avg = WIN_W'(win);
      end
      if (k == newNAt) n_avg = WIN_W'(newN);
      if (abortK >= 0 && k == abortK) en_pm = 1'b0;
      applyStimulus(mode, k);
      @(posedge clk);
      #1;
      aborted = (abortK >= 0) && (k >= abortK);
      if (!aborted && k >= ARM_CYC + 1 && k <= ARM_CYC + win) begin
        si = inLog[k - SYNC_LAT];
        sr = refLog[k - SYNC_LAT];
        if (si != sr) expDiff++;
        if (si && !sr) expLead++;
      end
      if (aborted) begin
        expDiff = 0;
        expLead = 0;
      end
      if (abortK >= 0) expActive = (k >= 1) && (k <= abortK);
      else expActive = (k >= 1) && (k <= ARM_CYC + win);
      expDone = (abortK < 0) && (k >= 1 + ARM_CYC + win);
      checkOutput("en_sync", 32'(en_sync), 32'(expActive));
      checkOutput("busy", 32'(busy), 32'(expActive));
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("cnt_diff", 32'(cnt_diff), 32'(expDiff));
      checkOutput("cnt_lead", 32'(cnt_lead), 32'(expLead));
    end
    if (abortK < 0) begin
      @(negedge clk);
      en_pm = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("hold_diff", 32'(cnt_diff), 32'(expDiff));
      @(negedge clk);
      @(posedge clk);
      #1;
      checkOutput("done_clear", 32'(done), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_en_sync", 32'(en_sync), 32'd0);
      checkOutput("idle_diff", 32'(cnt_diff), 32'(expDiff));
      checkOutput("idle_lead", 32'(cnt_lead), 32'(expLead));
    end
  endtask

  initial begin
    rst    = 1'b1;
    en_pm  = 1'b1;
    ff_in  = 1'b1;
    ff_ref = 1'b1;
    n_avg  = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst    = 1'b1;
      en_pm  = 1'b1;
      ff_in  = 1'b1;
      ff_ref = 1'b1;
      n_avg  = WIN_W'(100);
      @(posedge clk);
      #1;
      checkOutput("rst_en_sync", 32'(en_sync), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_diff", 32'(cnt_diff), 32'd0);
      checkOutput("rst_lead", 32'(cnt_lead), 32'd0);
    end

    runMeasure(100, 0, -1, 0, -1, 0);
    checkOutput("lead_diff100", 32'(cnt_diff), 32'd100);
    checkOutput("lead_lead100", 32'(cnt_lead), 32'd100);

    runMeasure(64, 1, -1, 0, -1, 0);
    checkOutput("alt_diff32", 32'(cnt_diff), 32'd32);
    checkOutput("alt_lead32", 32'(cnt_lead), 32'd32);

    runMeasure(64, 2, -1, 0, -1, 0);
    checkOutput("same_diff0", 32'(cnt_diff), 32'd0);
    checkOutput("same_lead0", 32'(cnt_lead), 32'd0);

    runMeasure(0, 0, -1, 0, -1, 0);
    checkOutput("zero_diff", 32'(cnt_diff), 32'd0);

    runMeasure(50, 3, 1 + ARM_CYC + 10, 0, -1, 0);
    runMeasure(50, 3, -1, 0, -1, 0);

    runMeasure(20, 3, -1, 300, 10, 5);

    for (int r = 0; r < 4; r++) begin
      runMeasure(int'($urandom_range(1, 40)), 3, -1, 0, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
